// File: rtl/spc_timer_bank_if.sv
// Register-access bundle between the SPC700 I/O decode and the timer bank.
// The master drives strobes and selects; the slave returns counter state.
interface spc_timer_bank_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned OUT_W  = 4
);
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              ce;
  logic              en_wr;
  logic [NUM_CH-1:0] en_data;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [DIV_W-1:0]  div_data;
  logic              out_rd;
  logic [SEL_W-1:0]  out_sel;
  logic [OUT_W-1:0]  out_data;
  logic [NUM_CH-1:0] enabled;
  logic [NUM_CH-1:0] irq_mask;
  logic [NUM_CH-1:0] irq;
  logic [NUM_CH-1:0] ovf;

  modport master (
    output ce, en_wr, en_data, div_wr, div_sel, div_data, out_rd, out_sel, irq_mask,
    input  out_data, enabled, irq, ovf
  );

  modport slave (
    input  ce, en_wr, en_data, div_wr, div_sel, div_data, out_rd, out_sel, irq_mask,
    output out_data, enabled, irq, ovf
  );
endinterface

// File: rtl/spc_timer_bank.sv
// Bank of SPC700-style interval timers: shared prescaler, per-channel stage divider,
// read-to-clear output counter, sticky overflow flag and maskable interrupt.
module spc_timer_bank #(
  parameter int unsigned       NUM_CH    = 3,
  parameter int unsigned       DIV_W     = 8,
  parameter int unsigned       OUT_W     = 4,
  parameter int unsigned       PRE_SLOW  = 128,
  parameter int unsigned       PRE_FAST  = 16,
  parameter logic [NUM_CH-1:0] FAST_MASK = NUM_CH'(4)
) (
  input  logic               CLK,
  input  logic               RST_N,
  spc_timer_bank_if.slave    bus
);

  localparam int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PRE_W  = $clog2(PRE_SLOW);
  localparam int unsigned FAST_W = $clog2(PRE_FAST);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] irq_q, irq_d;
  logic [DIV_W-1:0]  stage_q  [NUM_CH];
  logic [DIV_W-1:0]  stage_d  [NUM_CH];
  logic [DIV_W-1:0]  target_q [NUM_CH];
  logic [DIV_W-1:0]  target_d [NUM_CH];
  logic [OUT_W-1:0]  out_q    [NUM_CH];
  logic [OUT_W-1:0]  out_d    [NUM_CH];

  logic              slow_tick;
  logic              fast_tick;
  logic [NUM_CH-1:0] tick;

  // Prescaler is free-running; channel enables never gate it.
  always_comb begin
    pre_d     = bus.ce ? pre_q + 1'b1 : pre_q;
    slow_tick = bus.ce & (&pre_q);
    fast_tick = bus.ce & (&pre_q[FAST_W-1:0]);
    for (int i = 0; i < NUM_CH; i++) begin
      tick[i] = FAST_MASK[i] ? fast_tick : slow_tick;
    end
  end

  // Priority within a channel: count, then read-clear, then enable-rise clear.
  always_comb begin
    logic [DIV_W-1:0] s_next;
    logic             match;
    logic             rd_hit;

    en_d     = en_q;
    ovf_d    = ovf_q;
    stage_d  = stage_q;
    target_d = target_q;
    out_d    = out_q;
    s_next   = '0;
    match    = 1'b0;
    rd_hit   = 1'b0;

    for (int i = 0; i < NUM_CH; i++) begin
      s_next = stage_q[i] + 1'b1;
      match  = en_q[i] & tick[i] & (s_next == target_q[i]);
      rd_hit = bus.out_rd & (bus.out_sel == SEL_W'(i));

      if (en_q[i] & tick[i]) begin
        if (match) begin
          stage_d[i] = '0;
          out_d[i]   = out_q[i] + 1'b1;
          if (&out_q[i]) begin
            ovf_d[i] = 1'b1;
          end
        end else begin
          stage_d[i] = s_next;
        end
      end

      if (rd_hit) begin
        out_d[i] = match ? OUT_W'(1) : '0;
        ovf_d[i] = 1'b0;
      end

      if (bus.div_wr && (bus.div_sel == SEL_W'(i))) begin
        target_d[i] = bus.div_data;
      end

      if (bus.en_wr) begin
        en_d[i] = bus.en_data[i];
        if (bus.en_data[i] && !en_q[i]) begin
          stage_d[i] = '0;
          out_d[i]   = '0;
          ovf_d[i]   = 1'b0;
        end
      end

      irq_d[i] = bus.irq_mask[i] & (out_q[i] != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pre_q <= '0;
      en_q  <= '0;
      ovf_q <= '0;
      irq_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        stage_q[i]  <= '0;
        target_q[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      pre_q    <= pre_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      stage_q  <= stage_d;
      target_q <= target_d;
      out_q    <= out_d;
    end
  end

  // Selects beyond the last channel read back as zero.
  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.out_sel == SEL_W'(i)) begin
        bus.out_data = out_q[i];
      end
    end
  end

  assign bus.enabled = en_q;
  assign bus.irq     = irq_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_spc_timer_bank.sv
// Directed bench for spc_timer_bank: stimulus queues expected values, a negedge
// monitor pops and compares them against the bank's outputs.
module tb_spc_timer_bank;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned OUT_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spc_timer_bank_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .OUT_W(OUT_W)) bus ();

  spc_timer_bank #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .OUT_W    (OUT_W),
    .PRE_SLOW (128),
    .PRE_FAST (16),
    .FAST_MASK(3'b100)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  typedef enum int {KOut, KEn, KIrq, KOvf} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] exp;
    string      name;
  } item_t;

  item_t      sb_q[$];
  item_t      mon_it;
  logic [7:0] mon_act;
  int         checks   = 0;
  int         failures = 0;

  task automatic expect_val(kind_e k, int e, string n);
    item_t it;
    it.kind = k;
    it.exp  = 8'(e);
    it.name = n;
    sb_q.push_back(it);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_it = sb_q.pop_front();
      case (mon_it.kind)
        KOut:    mon_act = 8'(bus.out_data);
        KEn:     mon_act = 8'(bus.enabled);
        KIrq:    mon_act = 8'(bus.irq);
        default: mon_act = 8'(bus.ovf);
      endcase
      checks++;
      if (mon_act !== mon_it.exp) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", mon_it.name, mon_act, mon_it.exp);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ce_run(int n);
    bus.ce = 1'b1;
    cyc(n);
    bus.ce = 1'b0;
  endtask

  task automatic en_write(logic [2:0] d);
    bus.en_wr   = 1'b1;
    bus.en_data = d;
    cyc(1);
    bus.en_wr   = 1'b0;
  endtask

  task automatic div_write(int ch, int d);
    bus.div_wr   = 1'b1;
    bus.div_sel  = 2'(ch);
    bus.div_data = 8'(d);
    cyc(1);
    bus.div_wr   = 1'b0;
  endtask

  task automatic rd(int ch);
    bus.out_sel = 2'(ch);
    bus.out_rd  = 1'b1;
    cyc(1);
    bus.out_rd  = 1'b0;
  endtask

  task automatic chk_out(int ch, int e, string n);
    bus.out_sel = 2'(ch);
    expect_val(KOut, e, n);
    cyc(1);
  endtask

  task automatic chk(kind_e k, int e, string n);
    expect_val(k, e, n);
    cyc(1);
  endtask

  initial begin
    bus.ce       = 1'b0;
    bus.en_wr    = 1'b0;
    bus.en_data  = '0;
    bus.div_wr   = 1'b0;
    bus.div_sel  = '0;
    bus.div_data = '0;
    bus.out_rd   = 1'b0;
    bus.out_sel  = '0;
    bus.irq_mask = '0;
    cyc(2);
    rst_n = 1'b1;
    chk_out(0, 0, "rst_out0");
    chk(KEn, 0, "rst_en");
    chk(KIrq, 0, "rst_irq");
    chk(KOvf, 0, "rst_ovf");

    // Slow channel, divide by 2: 768 CE = 6 slow ticks = 3 matches
    div_write(0, 2);
    en_write(3'b001);
    ce_run(768);
    chk_out(0, 3, "t1_out0");
    chk_out(1, 0, "t1_out1");
    chk_out(2, 0, "t1_out2");

    // Fast channel, target 0 means 256 ticks per match
    div_write(2, 0);
    en_write(3'b100);
    ce_run(4095);
    chk_out(2, 0, "t2_out2_4095");
    ce_run(1);
    chk_out(2, 1, "t2_out2_4096");
    chk_out(0, 3, "t2_out0_held");
    chk(KEn, 4, "t2_en");

    // Output counter wrap sets sticky overflow
    div_write(2, 1);
    en_write(3'b000);
    en_write(3'b100);
    ce_run(240);
    chk_out(2, 15, "t4_out2_15");
    chk(KOvf, 0, "t4_ovf_pre");
    ce_run(16);
    chk_out(2, 0, "t4_out2_wrap");
    chk(KOvf, 4, "t4_ovf_set");
    rd(2);
    chk(KOvf, 0, "t4_ovf_clr");

    // Read on the same edge as a match
    div_write(0, 1);
    en_write(3'b001);
    ce_run(128);
    chk_out(0, 1, "t3_pre");
    bus.out_sel = 2'd0;
    bus.ce      = 1'b1;
    cyc(127);
    bus.out_rd  = 1'b1;
    expect_val(KOut, 1, "t3_rd_old");
    cyc(1);
    bus.out_rd  = 1'b0;
    bus.ce      = 1'b0;
    chk_out(0, 1, "t3_after");

    // IRQ follows out by one cycle
    bus.irq_mask = 3'b001;
    cyc(1);
    chk(KIrq, 1, "t6_irq_pre");
    rd(0);
    expect_val(KIrq, 1, "t6_irq_hold");
    cyc(1);
    expect_val(KIrq, 0, "t6_irq_clr");
    cyc(1);
    ce_run(128);
    bus.out_sel = 2'd0;
    expect_val(KOut, 1, "t6_out0");
    expect_val(KIrq, 0, "t6_irq_lag");
    cyc(1);
    expect_val(KIrq, 1, "t6_irq_rise");
    cyc(1);
    rd(0);
    expect_val(KIrq, 1, "t6_irq_rd_lag");
    cyc(1);
    expect_val(KIrq, 0, "t6_irq_fall");
    cyc(1);
    bus.irq_mask = 3'b000;

    // Enable rewrite semantics and out-of-range select
    div_write(1, 1);
    en_write(3'b010);
    ce_run(640);
    chk_out(1, 5, "t5_out1_5");
    en_write(3'b010);
    chk_out(1, 5, "t5_en_11");
    chk_out(3, 0, "t5_sel_oob");
    rd(3);
    div_write(3, 7);
    chk_out(1, 5, "t5_rd_oob");
    div_write(1, 3);
    ce_run(128);
    chk_out(1, 5, "t5_stage1");
    en_write(3'b000);
    chk_out(1, 5, "t5_halt");
    chk(KEn, 0, "t5_en_off");
    en_write(3'b010);
    chk_out(1, 0, "t5_reen");
    ce_run(256);
    chk_out(1, 0, "t5_stage_clr");
    ce_run(128);
    chk_out(1, 1, "t5_match");

    // Reset mid-count leaves no residue
    bus.irq_mask = 3'b001;
    div_write(0, 1);
    en_write(3'b001);
    ce_run(896);
    chk_out(0, 7, "t7_out0_7");
    chk(KIrq, 1, "t7_irq_pre");
    ce_run(50);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk_out(0, 0, "t7_out0");
    chk_out(1, 0, "t7_out1");
    chk(KEn, 0, "t7_en");
    chk(KIrq, 0, "t7_irq");
    chk(KOvf, 0, "t7_ovf");
    div_write(0, 1);
    en_write(3'b001);
    ce_run(127);
    chk_out(0, 0, "t7_no_residue");
    ce_run(1);
    chk_out(0, 1, "t7_first_tick");

    cyc(2);
    if (sb_q.size() != 0) begin
      failures += sb_q.size();
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
